// File: rtl/corerv_pkg.sv
// Shared definitions for the RV32 core front end.
//   XLEN / RESET_PC_DEFAULT : data-path width and default boot address
//   axi_resp_e              : AXI read-response encodings
//   fetch_entry_t           : one buffered fetch result {pc, instr, fault}
//   ar_state_e              : read-address channel hold state
//   word_align()            : clears the two low address bits
package corerv_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

  // HOLD_STALE: the held request was issued before a redirect, so its
  // acceptance must not advance the (already redirected) fetch PC.
  typedef enum logic [1:0] {
    AR_IDLE,
    AR_HOLD,
    AR_HOLD_STALE
  } ar_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch_entry_t.
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data (ignored when full and not popping)
//   push_data   : entry to enqueue
//   pop         : remove head entry (ignored when empty)
//   flush       : drop all entries (wins over push/pop)
//   full, empty : occupancy flags
//   count       : number of valid entries
//   head        : oldest entry, straight from a storage register
module fetch_fifo
  import corerv_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [CW-1:0]  r_count;

  fetch_entry_t   w_mem_nxt [DEPTH];
  logic           w_pop;
  logic           w_push;
  logic [AW-1:0]  w_wr_idx;

  // Shift-down organisation keeps the head permanently in slot 0.
  always_comb begin
    w_pop    = pop && (r_count != '0);
    w_push   = push && ((r_count != CW'(DEPTH)) || w_pop);
    w_wr_idx = AW'(r_count - CW'(w_pop));
    w_mem_nxt = r_mem;
    if (w_pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        w_mem_nxt[i] = r_mem[i+1];
      end
    end
    if (w_push) begin
      w_mem_nxt[w_wr_idx] = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_mem   <= w_mem_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[0];

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage.
//   clk, rst                     : clock, synchronous active-high reset
//   imem_ar{addr,valid,ready}    : instruction-memory read-address channel
//   imem_r{data,resp,valid,ready}: instruction-memory read-data channel
//   instr_o, pc_o, instr_fault_o : buffered instruction, its PC, fault flag
//   instr_valid_o, instr_ready_i : handshake towards decode
//   redirect_i, redirect_pc_i    : flush buffer and restart fetch at new PC
module fetch_unit
  import corerv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_araddr,
  output logic            imem_arvalid,
  input  logic            imem_arready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic [1:0]      imem_rresp,
  input  logic            imem_rvalid,
  output logic            imem_rready,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_fault_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ar_state_e       r_ar_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [XLEN-1:0] r_araddr;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  ar_state_e       w_ar_state_nxt;
  logic            w_can_issue;
  logic            w_arvalid;
  logic            w_ar_hs;
  logic            w_r_hs;
  logic [CW-1:0]   w_out_nxt;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_entry;
  fetch_entry_t    w_head;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;

  always_comb begin
    // Credits: every in-flight request already owns a buffer slot.
    w_can_issue = (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CW+1)'(FIFO_DEPTH))
               && (r_outstanding < CW'(MAX_OUTSTANDING));
    w_arvalid   = 1'b0;
    if (!rst) begin
      w_arvalid = (r_ar_state != AR_IDLE) || (w_can_issue && !redirect_i);
    end
    w_ar_hs    = w_arvalid && imem_arready;
    w_r_hs     = imem_rvalid && !rst;
    w_out_nxt  = r_outstanding + CW'(w_ar_hs) - CW'(w_r_hs);
    w_push_req = w_r_hs && (r_drop_cnt == '0) && !redirect_i;
    w_push     = w_push_req && (!w_fifo_full || w_pop);
    w_pop      = !w_fifo_empty && instr_ready_i;
    w_entry    = '{pc: r_resp_pc, instr: imem_rdata, fault: (imem_rresp != RESP_OKAY)};

    w_ar_state_nxt = r_ar_state;
    unique case (r_ar_state)
      AR_IDLE:       if (w_arvalid && !imem_arready) w_ar_state_nxt = AR_HOLD;
      AR_HOLD:       if (imem_arready)               w_ar_state_nxt = AR_IDLE;
                     else if (redirect_i)            w_ar_state_nxt = AR_HOLD_STALE;
      AR_HOLD_STALE: if (imem_arready)               w_ar_state_nxt = AR_IDLE;
      default:                                       w_ar_state_nxt = AR_IDLE;
    endcase

    imem_arvalid = w_arvalid;
    imem_araddr  = (r_ar_state == AR_IDLE) ? r_fetch_pc : r_araddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar_state <= AR_IDLE;
    end else begin
      r_ar_state <= w_ar_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_araddr      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_araddr      <= imem_araddr;
      r_outstanding <= w_out_nxt;
      if (redirect_i) begin
        r_fetch_pc <= word_align(redirect_pc_i);
        r_resp_pc  <= word_align(redirect_pc_i);
        // A still-held request will be answered later, so it is stale too.
        r_drop_cnt <= w_out_nxt + CW'(w_arvalid && !imem_arready);
      end else begin
        if (w_ar_hs && (r_ar_state != AR_HOLD_STALE)) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_r_hs && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_entry),
    .pop       (w_pop),
    .flush     (redirect_i),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count),
    .head      (w_head)
  );

  assign imem_rready   = 1'b1;
  assign instr_o       = w_head.instr;
  assign pc_o          = w_head.pc;
  assign instr_fault_o = w_head.fault;
  assign instr_valid_o = !w_fifo_empty;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32 core. It issues sequential read requests on the AXI-style instruction-memory read channels (AR/R) and buffers the returned words with their PCs. It delivers them in order to the decode stage over a valid/ready handshake. A redirect input from execute flushes the buffer, discards stale in-flight responses and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, instruction buffer entries; ≥2, power of two
- MAX_OUTSTANDING, 4, max AR accepted without R; ≤FIFO_DEPTH

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- imem_araddr  out  32  read address, word aligned
- imem_arvalid  out  1  read address valid
- imem_arready  in  1  memory accepts address
- imem_rdata  in  32  instruction word
- imem_rresp  in  2  response; 2'b00 OKAY, anything else is a fault
- imem_rvalid  in  1  response valid
- imem_rready  out  1  response accepted; tied 1 after reset
- instr_o  out  32  instruction to decode
- pc_o  out  32  PC of instr_o
- instr_fault_o  out  1  instr_o came from a non-OKAY response
- instr_valid_o  out  1  instr_o/pc_o/instr_fault_o valid
- instr_ready_i  in  1  decode consumes the entry this cycle
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  32  restart PC; bits [1:0] ignored (forced 0)

## Operation
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next accepted response.
  - outstanding: AR handshakes not yet answered by R.
  - drop_cnt: stale responses still to discard.
  - FIFO of {pc, instr, fault}.
- Issue:
  - imem_arvalid rises when no AR is pending and outstanding + FIFO occupancy < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
  - Once asserted, imem_arvalid and imem_araddr hold stable until imem_arready. This holds across redirects.
  - On the AR handshake: fetch_pc += 4 and outstanding += 1.
- Response: on imem_rvalid (rready is always 1), outstanding -= 1.
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise: push {resp_pc, rdata, rresp != 0} and resp_pc += 4.
  - A fault does not stop fetch.
- Output: the FIFO head drives instr_o, pc_o and instr_fault_o. A pop occurs when instr_valid_o && instr_ready_i.
- Redirect (highest priority):
  - Flush the FIFO.
  - fetch_pc and resp_pc := {redirect_pc_i[31:2], 2'b00}.
  - drop_cnt := outstanding after this cycle's AR/R handshakes, plus 1 if an AR is still pending unaccepted.
  - New requests begin only after any pending AR is accepted.
- A pop in the same cycle as redirect_i is a completed transfer; decode discards it itself.
- Push in the redirect cycle is suppressed; the response counts as dropped if it was stale.
- FIFO full: cannot occur on push, because credits reserve space. The bench asserts no overflow.
- The 32-bit PC wraps from 0xFFFF_FFFC to 0x0000_0000 with no error.

## Timing
- Reset values:
  - imem_arvalid=0, imem_araddr=RESET_PC, imem_rready=1.
  - instr_valid_o=0, instr_o=0, pc_o=0, instr_fault_o=0.
  - Counters 0, FIFO empty.
- The first imem_arvalid is asserted in the first cycle after rst deasserts.
- Latency: an R handshake in cycle n gives instr_valid_o in cycle n+1, because the FIFO output is registered.
- With arready=1 and a 1-cycle memory, throughput is one instruction per cycle once filled.
- After redirect_i in cycle n:
  - instr_valid_o=0 in n+1.
  - The first new AR is in n+1 if no AR was pending.
- rst asserted mid-operation returns all state to reset values on the next edge. In-flight memory responses are the memory's responsibility, since memory is reset together with the core.

## Structure
- Shared package corerv_pkg holds:
  - XLEN=32 and the RESET_PC default.
  - AXI resp encodings (RESP_OKAY etc.).
  - The packed fetch_entry_t {pc, instr, fault}.
- Sub-module fetch_fifo: a synchronous FIFO of fetch_entry_t with parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Registered head output.
- fetch_unit holds the PC, counters and issue logic.

## Test plan
- Reset, arready=1, memory returns araddr as data with 1-cycle latency, ready=1:
  - AR sequence 0x0, 0x4, 0x8, …
  - instr_valid_o first high 3 cycles after reset release, then every cycle.
  - pc_o equals instr_o.
- instr_ready_i=0 for 10 cycles:
  - At most FIFO_DEPTH ARs are issued.
  - instr_o stays 0x0, no overflow.
  - On release, 0x0, 0x4, 0x8, 0xC come out in order.
- Memory latency 3 cycles, then redirect_i with redirect_pc_i=0x103 while 2 requests are outstanding:
  - Both stale responses are dropped.
  - The next delivered pc_o=0x100, then 0x104.
- redirect_i while imem_arvalid is high and imem_arready is held 0 for 2 cycles:
  - imem_araddr stays stable until accepted.
  - Its response is dropped.
  - Fetch resumes at the redirect PC.
- imem_rresp=2'b10 on the word at 0x8:
  - Delivered with instr_fault_o=1 and pc_o=0x8.
  - 0xC follows normally with instr_fault_o=0.
- rst asserted mid-stream with RESET_PC=0x8000_0000:
  - All outputs return to reset values next cycle.
  - Fetch restarts at 0x8000_0000.
